div_unit_iter: RTL

- Iterative multi-cycle divider for the RV32M extension, executing DIV, DIVU, REM and REMU.
- Built on repeated restoring subtraction, one quotient bit per cycle.
- Sits beside the EX-stage ALU. The pipeline holds EX while the unit is busy and takes the result when done pulses.
- Results follow the RISC-V special-case rules exactly; no traps are raised.

---
 rtl/div_unit_iter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/div_unit_iter.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic            neg_quot;
  logic            neg_rem;
  logic [CW-1:0]   cnt;

  // Operand decode for the accepting edge
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;
  logic            early;
  logic            special;
  logic            accept;
  logic [XLEN-1:0] imm_quot;
  logic [XLEN-1:0] imm_rem;
  logic [XLEN-1:0] imm_result;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor  : divisor;
    div_zero  = (divisor == '0);
    overflow  = is_signed & (dividend == INT_MIN) & (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = ~div_zero & (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
    special   = div_zero | overflow | early;
    accept    = start & ~flush & ((state == S_IDLE) | (state == S_DONE));

    // Early-out falls through to quotient 0 with the untouched dividend as remainder
    imm_quot  = '0;
    imm_rem   = dividend;
    if (div_zero) begin
      imm_quot = '1;
      imm_rem  = dividend;
    end else if (overflow) begin
      imm_quot = INT_MIN;
      imm_rem  = '0;
    end
    imm_result = op[1] ? imm_rem : imm_quot;
  end

  // One restoring step on {rem, quot}
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fin_result;

  always_comb begin
    rem_sh     = {rem_q, quot_q[XLEN-1]};
    trial      = rem_sh - {1'b0, div_q};
    fits       = (rem_sh >= {1'b0, div_q});
    rem_nx     = fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_nx    = {quot_q[XLEN-2:0], fits};
    quot_fix   = neg_quot ? -quot_nx : quot_nx;
    rem_fix    = neg_rem  ? -rem_nx  : rem_nx;
    fin_result = op_q[1] ? rem_fix : quot_fix;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      op_q     <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_q     <= op;
      div_q    <= b_mag;
      rem_q    <= '0;
      quot_q   <= a_mag;
      neg_quot <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      cnt      <= '0;
      if (special) begin
        state  <= S_DONE;
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= imm_result;
      end else begin
        state <= S_CALC;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else begin
      case (state)
        S_CALC: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          if (cnt == LAST_STEP) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin_result;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
